// File: rtl/cc_branch_unit_pkg.sv
// Shared LC-3b types for the condition-code / branch-resolve slice.
// Imported by cc_branch_unit.
package lc3b_types;

   typedef logic [15:0] lc3b_word;
   typedef logic [2:0]  lc3b_nzp;

   localparam lc3b_nzp CC_RESET = 3'b010;

endpackage

// File: rtl/cc_branch_unit_mux2_w.sv
// Generic two-input word multiplexer: f = sel ? b : a.
module mux2_w #(
   parameter int width = 16
) (
   input  logic             sel,
   input  logic [width-1:0] a,
   input  logic [width-1:0] b,
   output logic [width-1:0] f
);

   assign f = sel ? b : a;

endmodule

// File: rtl/cc_branch_unit.sv
// LC-3b memory-stage write-back select, NZP generation, CC register and BR resolve.
// Optional branch statistics counters are enabled by defining BR_COUNTERS_EN.
module cc_branch_unit
   import lc3b_types::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] word_in,
   input  logic [WIDTH-1:0] rdata,
   input  logic             byte_addr,
   input  logic             byte_sel,
   input  logic             load_cc,
   input  logic             is_br,
   input  logic [2:0]       nzp,
   output logic [WIDTH-1:0] wb_out,
   output logic [2:0]       gencc_out,
   output logic [2:0]       cc_out,
   output logic             br_en
`ifdef BR_COUNTERS_EN
   ,
   output logic [WIDTH-1:0] br_count,
   output logic [WIDTH-1:0] br_taken_count
`endif
);

   localparam int HALF = WIDTH / 2;

   logic [HALF-1:0]  byte_lane;
   logic [WIDTH-1:0] byte_ext;
   lc3b_nzp          cc_q;

   mux2_w #(.width(HALF)) u_lane_mux (
      .sel (byte_addr),
      .a   (rdata[HALF-1:0]),
      .b   (rdata[WIDTH-1:HALF]),
      .f   (byte_lane)
   );

   // Byte loads are unsigned: the upper half is always zero.
   assign byte_ext = {{(WIDTH - HALF){1'b0}}, byte_lane};

   mux2_w #(.width(WIDTH)) u_wb_mux (
      .sel (byte_sel),
      .a   (word_in),
      .b   (byte_ext),
      .f   (wb_out)
   );

   always_comb begin
      gencc_out = 3'b001;
      if (wb_out[WIDTH-1]) begin
         gencc_out = 3'b100;
      end else if (wb_out == '0) begin
         gencc_out = 3'b010;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cc_q <= CC_RESET;
      end else if (load_cc) begin
         cc_q <= gencc_out;
      end
   end

   assign cc_out = cc_q;

   // Compare against the registered CC, so a same-cycle load is seen one cycle later.
   assign br_en = is_br & |(nzp & cc_q);

`ifdef BR_COUNTERS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         br_count       <= '0;
         br_taken_count <= '0;
      end else begin
         if (is_br) begin
            br_count <= br_count + 1'b1;
         end
         if (br_en) begin
            br_taken_count <= br_taken_count + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cc_branch_unit.sv
// Self-checking bench for cc_branch_unit: directed scenarios plus randomized traffic
// against a behavioural model. Define BR_COUNTERS_EN to also cover the counters.
module tb_cc_branch_unit;

   logic        clk;
   logic        reset;
   logic [15:0] word_in;
   logic [15:0] rdata;
   logic        byte_addr;
   logic        byte_sel;
   logic        load_cc;
   logic        is_br;
   logic [2:0]  nzp;
   logic [15:0] wb_out;
   logic [2:0]  gencc_out;
   logic [2:0]  cc_out;
   logic        br_en;
`ifdef BR_COUNTERS_EN
   logic [15:0] br_count;
   logic [15:0] br_taken_count;
`endif

   int n_checks = 0;
   int n_errors = 0;

   logic [2:0] model_cc;
   int         model_count;
   int         model_taken;

   cc_branch_unit #(.WIDTH(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .word_in   (word_in),
      .rdata     (rdata),
      .byte_addr (byte_addr),
      .byte_sel  (byte_sel),
      .load_cc   (load_cc),
      .is_br     (is_br),
      .nzp       (nzp),
      .wb_out    (wb_out),
      .gencc_out (gencc_out),
      .cc_out    (cc_out),
      .br_en     (br_en)
`ifdef BR_COUNTERS_EN
      ,
      .br_count       (br_count),
      .br_taken_count (br_taken_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] exp_wb();
      if (byte_sel) return (rdata >> (byte_addr ? 8 : 0)) & 16'h00FF;
      return word_in;
   endfunction

   function automatic logic [2:0] exp_flags(input logic [15:0] v);
      if ($signed(v) < 0) return 3'b100;
      if (v == 16'd0) return 3'b010;
      return 3'b001;
   endfunction

   function automatic logic exp_br();
      return is_br && ((nzp & model_cc) != 3'b000);
   endfunction

   task automatic apply_stimulus(input logic rst, input logic [15:0] w, input logic [15:0] rd,
                                 input logic ba, input logic bs, input logic ld,
                                 input logic br, input logic [2:0] n);
      reset = rst; word_in = w; rdata = rd; byte_addr = ba; byte_sel = bs;
      load_cc = ld; is_br = br; nzp = n;
      #1;
   endtask

   // Advance one clock, updating the model with what the edge should do.
   task automatic tick();
      logic [2:0] nxt_cc;
      int         nxt_count;
      int         nxt_taken;
      nxt_cc = model_cc;
      nxt_count = model_count;
      nxt_taken = model_taken;
      if (reset) begin
         nxt_cc = 3'b010;
         nxt_count = 0;
         nxt_taken = 0;
      end else begin
         if (load_cc) nxt_cc = exp_flags(exp_wb());
         if (is_br) nxt_count = (model_count + 1) % 65536;
         if (exp_br()) nxt_taken = (model_taken + 1) % 65536;
      end
      @(posedge clk);
      model_cc = nxt_cc;
      model_count = nxt_count;
      model_taken = nxt_taken;
      #1;
   endtask

   task automatic test_reset();
      apply_stimulus(1'b1, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
      tick();
      apply_stimulus(1'b0, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010);
      n_checks++;
      if (cc_out !== 3'b010) begin
         n_errors++;
         $display("[TB] FAIL reset_cc: got %b expected 010", cc_out);
      end
      n_checks++;
      if (br_en !== 1'b1) begin
         n_errors++;
         $display("[TB] FAIL reset_br_z: got %b expected 1", br_en);
      end
      apply_stimulus(1'b0, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'b101);
      n_checks++;
      if (br_en !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL reset_br_np: got %b expected 0", br_en);
      end
   endtask

   task automatic test_word_cc();
      logic [15:0] words [3] = '{16'h8000, 16'h0000, 16'h7FFF};
      logic [2:0]  flags [3] = '{3'b100, 3'b010, 3'b001};
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'b0, words[i], 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
         n_checks++;
         if (gencc_out !== flags[i]) begin
            n_errors++;
            $display("[TB] FAIL word_gencc[%0d]: got %b expected %b", i, gencc_out, flags[i]);
         end
         tick();
         n_checks++;
         if (cc_out !== flags[i]) begin
            n_errors++;
            $display("[TB] FAIL word_cc[%0d]: got %b expected %b", i, cc_out, flags[i]);
         end
      end
   endtask

   task automatic test_byte_path();
      for (int i = 0; i < 2; i++) begin
         logic [15:0] exp_v;
         exp_v = (i == 0) ? 16'h005A : 16'h00A5;
         apply_stimulus(1'b0, 16'hFFFF, 16'hA55A, i[0], 1'b1, 1'b0, 1'b0, 3'b000);
         n_checks++;
         if (wb_out !== exp_v) begin
            n_errors++;
            $display("[TB] FAIL byte_wb[%0d]: got %h expected %h", i, wb_out, exp_v);
         end
         n_checks++;
         if (gencc_out !== 3'b001) begin
            n_errors++;
            $display("[TB] FAIL byte_gencc[%0d]: got %b expected 001", i, gencc_out);
         end
      end
   endtask

   task automatic test_hazard();
      apply_stimulus(1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
      tick();
      apply_stimulus(1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 3'b100);
      n_checks++;
      if (br_en !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL hazard_same_cycle: got %b expected 0", br_en);
      end
      tick();
      apply_stimulus(1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100);
      n_checks++;
      if (br_en !== 1'b1) begin
         n_errors++;
         $display("[TB] FAIL hazard_next_cycle: got %b expected 1", br_en);
      end
   endtask

   task automatic test_hold();
      // CC is N here after the hazard scenario.
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(1'b0, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 3'b111);
         tick();
      end
      n_checks++;
      if (cc_out !== 3'b100) begin
         n_errors++;
         $display("[TB] FAIL hold_cc: got %b expected 100", cc_out);
      end
      n_checks++;
      if (br_en !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL hold_not_br: got %b expected 0", br_en);
      end
      // Reset must win over a simultaneous load.
      apply_stimulus(1'b1, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
      tick();
      apply_stimulus(1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001);
      n_checks++;
      if (cc_out !== 3'b010 || br_en !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL reset_over_load: got cc=%b br=%b expected cc=010 br=0", cc_out, br_en);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         apply_stimulus(($urandom_range(0, 15) == 0), 16'($urandom), 16'($urandom),
                        1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
         n_checks++;
         if (wb_out !== exp_wb() || gencc_out !== exp_flags(exp_wb()) || br_en !== exp_br()) begin
            n_errors++;
            $display("[TB] FAIL rand_comb[%0d]: got wb=%h cc=%b br=%b expected wb=%h cc=%b br=%b",
                     i, wb_out, gencc_out, br_en, exp_wb(), exp_flags(exp_wb()), exp_br());
         end
         tick();
         n_checks++;
         if (cc_out !== model_cc) begin
            n_errors++;
            $display("[TB] FAIL rand_cc[%0d]: got %b expected %b", i, cc_out, model_cc);
         end
`ifdef BR_COUNTERS_EN
         n_checks++;
         if (br_count !== 16'(model_count) || br_taken_count !== 16'(model_taken)) begin
            n_errors++;
            $display("[TB] FAIL rand_counts[%0d]: got %0d/%0d expected %0d/%0d",
                     i, br_count, br_taken_count, model_count, model_taken);
         end
`endif
      end
   endtask

`ifdef BR_COUNTERS_EN
   task automatic test_counters();
      logic [2:0] pattern [3] = '{3'b010, 3'b001, 3'b111};
      apply_stimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
      tick();
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, pattern[i]);
         tick();
      end
      n_checks++;
      if (br_count !== 16'd3 || br_taken_count !== 16'd2) begin
         n_errors++;
         $display("[TB] FAIL count_3_2: got %0d/%0d expected 3/2", br_count, br_taken_count);
      end
      apply_stimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'b111);
      tick();
      n_checks++;
      if (br_count !== 16'd0 || br_taken_count !== 16'd0) begin
         n_errors++;
         $display("[TB] FAIL count_reset: got %0d/%0d expected 0/0", br_count, br_taken_count);
      end
      apply_stimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
      for (int i = 0; i < 65535; i++) tick();
      n_checks++;
      if (br_count !== 16'hFFFF || br_taken_count !== 16'd0) begin
         n_errors++;
         $display("[TB] FAIL count_preload: got %h/%h expected ffff/0000", br_count, br_taken_count);
      end
      tick();
      n_checks++;
      if (br_count !== 16'h0000) begin
         n_errors++;
         $display("[TB] FAIL count_wrap: got %h expected 0000", br_count);
      end
   endtask
`endif

   initial begin
      model_cc = 3'b010;
      model_count = 0;
      model_taken = 0;
      $display("[TB] starting cc_branch_unit bench");
      test_reset();
      test_word_cc();
      test_byte_path();
      test_hazard();
      test_hold();
      test_random();
`ifdef BR_COUNTERS_EN
      test_counters();
`endif
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/cc_branch_unit.md
Name: cc_branch_unit

Overview:
- Write-back condition-code and branch-resolve unit for the LC-3b pipeline memory stage.
- Selects the write-back value: full word, or a zero-extended byte lane of read data.
- Generates NZP flags from that value and holds them in the CC register.
- Resolves BR instructions against the instruction nzp field and raises br_en for redirect.

Parameters:
WIDTH, 16, data word width; must be even, byte = WIDTH/2.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
word_in  input  WIDTH  full-word write-back candidate (ALU/PC/etc. already muxed)
rdata  input  WIDTH  memory read data
byte_addr  input  1  address bit 0; 0 = low byte, 1 = high byte
byte_sel  input  1  1 = write back zero-extended byte, 0 = word_in
load_cc  input  1  update CC register at next clock edge
is_br  input  1  current instruction is BR
nzp  input  3  instruction bits [11:9]: n, z, p request
wb_out  output  WIDTH  selected write-back value
gencc_out  output  3  combinational NZP of wb_out
cc_out  output  3  registered CC {n,z,p}
br_en  output  1  branch taken

Behaviour:
- Byte lane: rdata[7:0] when byte_addr=0, rdata[15:8] when byte_addr=1. Zero-extend to WIDTH.
- wb_out: byte_sel ? zero-extended byte : word_in. Purely combinational.
- gencc_out is always exactly one-hot:
  - 3'b100 when wb_out[WIDTH-1]=1.
  - 3'b010 when wb_out==0.
  - 3'b001 otherwise.
- CC register: on a rising edge with reset=1, cc_out <= 3'b010 (Z). Else if load_cc=1, cc_out <= gencc_out. Else hold.
- br_en = is_br & ((nzp[2]&cc_out[2]) | (nzp[1]&cc_out[1]) | (nzp[0]&cc_out[0])). Combinational, uses the registered CC.
- Simultaneous load_cc and is_br: br_en reflects the old cc_out; the new CC is visible the cycle after the edge.
- nzp=3'b000: br_en=0 always. nzp=3'b111 with is_br=1: br_en=1 always, since CC is always one-hot.
- is_br=0: br_en=0 regardless of CC.
- Reset asserted mid-operation: it overrides load_cc. br_en after reset is computed against Z.
- No handshake; zero-latency combinational paths, except CC with one-cycle latency.

Optional Feature:
- Macro BR_COUNTERS_EN.
- When defined, add two outputs, br_count (WIDTH) and br_taken_count (WIDTH).
  - br_count increments on every clock edge where is_br=1.
  - br_taken_count increments on every edge where br_en=1.
  - Both are cleared to 0 by reset, wrap modulo 2^WIDTH, and hold otherwise.
- When undefined, the ports and counters are absent and the remaining behaviour is identical.

Decomposition:
- Shared package lc3b_types provides:
  - lc3b_word (16-bit) and lc3b_nzp (3-bit) typedefs.
  - CC_RESET constant = 3'b010.
- One reusable sub-module, mux2_w: parameter width, ports sel, a, b, f, with f = sel ? b : a.
  - Instantiated twice: byte-lane select (width WIDTH/2) and write-back select (width WIDTH).
- gencc and the branch compare are inline logic.

Test Plan:
- Reset: assert reset one cycle -> cc_out=3'b010. With is_br=1, nzp=3'b010 -> br_en=1; with nzp=3'b101 -> br_en=0.
- Word CC: byte_sel=0, load_cc=1.
  - word_in=16'h8000 -> gencc_out=100, cc_out=100 next cycle.
  - 16'h0000 -> 010.
  - 16'h7FFF -> 001.
- Byte path: rdata=16'hA55A, byte_sel=1.
  - byte_addr=0 -> wb_out=16'h005A, gencc 001.
  - byte_addr=1 -> wb_out=16'h00A5, gencc 001 (zero-extend, not negative).
- Same-cycle hazard: cc_out=001, load_cc=1, word_in=16'hFFFF, is_br=1, nzp=100 -> br_en=0 this cycle; next cycle (load_cc=0) br_en=1.
- Hold: load_cc=0 for 5 cycles with varying word_in -> cc_out unchanged. is_br=0, nzp=111 -> br_en=0.
- BR_COUNTERS_EN defined: 3 BR cycles, 2 of them taken -> br_count=3, br_taken_count=2. Reset -> both 0. Preload to 16'hFFFF via BR cycles -> next BR wraps br_count to 0.
